// File: rtl/simon_serial_datapath_if.sv
// -----------------------------------------------------------------------------
// simon_serial_datapath_if
//   Signal bundle between the bit-serial Simon 128/128 datapath and its
//   surroundings (serial input source, key-schedule block, ciphertext sink).
//
//   start        begin an encryption (sampled only while idle)
//   data_in      shared serial input: key bits, then plaintext bits, LSB first
//   key_bit      current round-key bit from the key schedule (combinational)
//   data_rdy     phase code to the key schedule: 0 idle, 1 hold, 2 load, 3 run
//   bit_counter  bit index within the 64-bit word while running, else 0
//   ct_out       serial ciphertext bit, ct_valid marks it
//   busy         high whenever the datapath is not idle
//   done         one-cycle pulse after the last ciphertext bit
//   round_strobe one-cycle pulse per completed round
//                (present only when SIMON_ROUND_STROBE_EN is defined)
//
//   slave  : the datapath side
//   master : the side driving start/data_in/key_bit
// -----------------------------------------------------------------------------
interface simon_serial_datapath_if;
   logic       start;
   logic       data_in;
   logic       key_bit;
   logic [1:0] data_rdy;
   logic [5:0] bit_counter;
   logic       ct_out;
   logic       ct_valid;
   logic       busy;
   logic       done;
`ifdef SIMON_ROUND_STROBE_EN
   logic       round_strobe;

   modport slave (
      input  start, data_in, key_bit,
      output data_rdy, bit_counter, ct_out, ct_valid, busy, done, round_strobe
   );
   modport master (
      output start, data_in, key_bit,
      input  data_rdy, bit_counter, ct_out, ct_valid, busy, done, round_strobe
   );
`else
   modport slave (
      input  start, data_in, key_bit,
      output data_rdy, bit_counter, ct_out, ct_valid, busy, done
   );
   modport master (
      output start, data_in, key_bit,
      input  data_rdy, bit_counter, ct_out, ct_valid, busy, done
   );
`endif
endinterface

// File: rtl/simon_serial_datapath.sv
// -----------------------------------------------------------------------------
// simon_serial_datapath
//   Bit-serial Simon 128/128 encryption datapath and sequencer, one bit per
//   clock. Works beside a bit-serial key-expansion block: it drives that
//   block's phase code (data_rdy) and bit_counter and consumes its serial
//   round-key bit (key_bit), LSB first.
//
//   Sequence: IDLE -> LOAD_KEY (128 cycles, key schedule shifts data_in)
//          -> LOAD_PT (128 cycles, y then x sampled LSB first)
//          -> RUN (ROUNDS x 64 cycles) -> OUT (128 cycles, y then x) -> IDLE.
//
//   Ports: clk, rst (asynchronous, active high), bus (slave modport of
//   simon_serial_datapath_if, see that file for the signal list).
//
//   Optional: define SIMON_ROUND_STROBE_EN to add bus.round_strobe, a
//   registered pulse in the first cycle of each new round and of OUT.
// -----------------------------------------------------------------------------
module simon_serial_datapath #(
   parameter int unsigned ROUNDS = 68
) (
   input  logic                  clk,
   input  logic                  rst,
   simon_serial_datapath_if.slave bus
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_KEY = 3'd1;
   localparam logic [2:0] S_LOAD_PT  = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_OUT      = 3'd4;

   localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

   logic [2:0]  state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;       // load/out bit count; low 6 bits index RUN bits
   logic [6:0]  round_q, round_d;
   logic [63:0] x_q, x_d;
   logic [63:0] y_q, y_d;
   logic        ct_out_q, ct_out_d;
   logic        done_q, done_d;
   logic        new_x;
   logic        x_m1, x_m2, x_m8;
   logic [1:0]  data_rdy;

   // x and y rotate right one place per cycle, so bit i of the word being
   // processed always sits at position 0. Once bit j has been processed the
   // old x[j] lives in y (new_y = old x), so taps behind the current bit are
   // read from y; taps that wrap below bit 0 still find the untouched high
   // bits of the old x at the top of x.
   always_comb begin
      x_m1  = (cnt_q[5:0] == 6'd0) ? x_q[63] : y_q[63];
      x_m2  = (cnt_q[5:1] == 5'd0) ? x_q[62] : y_q[62];
      x_m8  = (cnt_q[5:3] == 3'd0) ? x_q[56] : y_q[56];
      new_x = y_q[0] ^ (x_m1 & x_m8) ^ x_m2 ^ bus.key_bit;
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      round_d = round_q;
      x_d     = x_q;
      y_d     = y_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_LOAD_KEY;
               cnt_d   = '0;
            end
         end
         S_LOAD_KEY: begin
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'd127) begin
               state_d = S_LOAD_PT;
               cnt_d   = '0;
            end
         end
         S_LOAD_PT: begin
            // {x,y} is one 128-bit chain: the first bit ends up in y[0]
            x_d   = {bus.data_in, x_q[63:1]};
            y_d   = {x_q[0], y_q[63:1]};
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'd127) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            x_d   = {new_x, x_q[63:1]};
            y_d   = {x_q[0], y_q[63:1]};
            cnt_d = {1'b0, cnt_q[5:0] + 6'd1};
            if (cnt_q[5:0] == 6'd63) begin
               if (round_q == LAST_ROUND) begin
                  state_d = S_OUT;
                  round_d = '0;
                  cnt_d   = '0;
               end else begin
                  round_d = round_q + 7'd1;
               end
            end
         end
         S_OUT: begin
            x_d   = {1'b0, x_q[63:1]};
            y_d   = {x_q[0], y_q[63:1]};
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'd127) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // ct_out is registered: load the bit that will sit at y[0] next cycle
      ct_out_d = (state_d == S_OUT) ? y_d[0] : 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge values of the others. The x/y datapath registers are reset
   // as well so an aborted run leaves no plaintext or key material behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         round_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         ct_out_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         round_q  <= round_d;
         x_q      <= x_d;
         y_q      <= y_d;
         ct_out_q <= ct_out_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      case (state_q)
         S_LOAD_KEY:       data_rdy = 2'd2;
         S_LOAD_PT, S_OUT: data_rdy = 2'd1;
         S_RUN:            data_rdy = 2'd3;
         default:          data_rdy = 2'd0;
      endcase
   end

   assign bus.data_rdy    = data_rdy;
   assign bus.bit_counter = (state_q == S_RUN) ? cnt_q[5:0] : 6'd0;
   assign bus.ct_out      = ct_out_q;
   assign bus.ct_valid    = (state_q == S_OUT);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;

`ifdef SIMON_ROUND_STROBE_EN
   logic round_strobe_q, round_strobe_d;

   // fires after bit 63 of every round, i.e. in the first cycle of the next
   // round or of OUT
   always_comb begin
      round_strobe_d = (state_q == S_RUN) && (cnt_q[5:0] == 6'd63);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) round_strobe_q <= 1'b0;
      else     round_strobe_q <= round_strobe_d;
   end

   assign bus.round_strobe = round_strobe_q;
`endif

endmodule

// File: tb/tb_simon_serial_datapath.sv
`timescale 1ns/1ps
module tb_simon_serial_datapath;

   localparam int ROUNDS      = 68;
   localparam int LAT_LOAD_PT = 129;
   localparam int LAT_RUN     = 257;
   localparam int LAT_OUT     = LAT_RUN + ROUNDS * 64;
   localparam int LAT_DONE    = LAT_OUT + 128;

   localparam logic [127:0] KAT_KEY = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
   localparam logic [127:0] KAT_PT  = {64'h6373656420737265, 64'h6c6c657661727420};
   localparam logic [127:0] KAT_CT  = {64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   simon_serial_datapath_if bus ();
   simon_serial_datapath #(.ROUNDS(ROUNDS)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- Simon 128/128 reference arithmetic ----------------
   function automatic logic [63:0] rol(input logic [63:0] v, input int s);
      return (v << s) | (v >> (64 - s));
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] v, input int s);
      return (v >> s) | (v << (64 - s));
   endfunction

   function automatic logic z_bit(input int i);
      string z2;
      z2 = "10101111011100000011010010011000101000010001111110010110110011";
      return z2[i % 62] == 8'h31;
   endfunction

   function automatic logic [63:0] next_key_word(input logic [63:0] a, input logic [63:0] b,
                                                 input int i);
      logic [63:0] t;
      t = ror(b, 3);
      t = t ^ ror(t, 1);
      return ~a ^ t ^ {63'd0, z_bit(i)} ^ 64'd3;
   endfunction

   function automatic logic [63:0] round_key(input logic [127:0] key, input int r);
      logic [63:0] a, b, n;
      int lim;
      a = key[63:0];
      b = key[127:64];
      lim = (r > 255) ? 255 : r;
      for (int i = 0; i < lim; i++) begin
         n = next_key_word(a, b, i);
         a = b;
         b = n;
      end
      return a;
   endfunction

   function automatic logic [127:0] simon_encrypt(input logic [127:0] key, input logic [127:0] pt);
      logic [63:0] x, y, t, a, b, n;
      x = pt[127:64];
      y = pt[63:0];
      a = key[63:0];
      b = key[127:64];
      for (int r = 0; r < ROUNDS; r++) begin
         t = x;
         x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ a;
         y = t;
         n = next_key_word(a, b, r);
         a = b;
         b = n;
      end
      return {x, y};
   endfunction

   // ---------------- key-schedule stand-in (reacts to data_rdy) ----------------
   logic [127:0] ks_key = '0;
   int           ks_round;
   logic [63:0]  ks_rk;
   logic         noise;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ks_round <= 0;
      end else begin
         if (bus.data_rdy == 2'd2) ks_key <= {bus.data_in, ks_key[127:1]};
         if (bus.data_rdy == 2'd0) ks_round <= 0;
         else if (bus.data_rdy == 2'd3 && bus.bit_counter == 6'd63) ks_round <= ks_round + 1;
      end
   end

   always_comb begin
      ks_rk       = round_key(ks_key, ks_round);
      bus.key_bit = (bus.data_rdy == 2'd3) ? ks_rk[bus.bit_counter] : noise;
   end

   // ---------------- behavioural model: cycle index since start edge ----------------
   int           m_n;
   logic [127:0] cur_key, cur_pt, exp_ct;
   logic [127:0] next_key, next_pt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_n <= 0;
      end else if (m_n == 0 || m_n == LAT_DONE) begin
         if (bus.start) begin
            m_n     <= 1;
            cur_key <= next_key;
            cur_pt  <= next_pt;
            exp_ct  <= simon_encrypt(next_key, next_pt);
         end else begin
            m_n <= 0;
         end
      end else begin
         m_n <= m_n + 1;
      end
   end

   // serial source: key then plaintext while loading, random noise otherwise
   initial begin
      bus.data_in = 1'b0;
      noise       = 1'b0;
      forever begin
         @(negedge clk);
         noise = 1'($urandom);
         if (m_n >= 1 && m_n < LAT_LOAD_PT)        bus.data_in = cur_key[m_n - 1];
         else if (m_n >= LAT_LOAD_PT && m_n < LAT_RUN) bus.data_in = cur_pt[m_n - LAT_LOAD_PT];
         else                                       bus.data_in = 1'($urandom);
      end
   end

   // ---------------- per-cycle comparison against the model ----------------
   always @(negedge clk) begin : cmp
      logic [1:0] e_rdy;
      logic [5:0] e_bc;
      logic       e_busy, e_done, e_valid, e_ct, e_str, a_str;
      e_rdy = 2'd0; e_bc = 6'd0; e_valid = 1'b0; e_ct = 1'b0; e_str = 1'b0; a_str = 1'b0;
      if (!rst) begin
         if (m_n == 0 || m_n == LAT_DONE) begin
            e_rdy = 2'd0;
         end else if (m_n < LAT_LOAD_PT) begin
            e_rdy = 2'd2;
         end else if (m_n < LAT_RUN) begin
            e_rdy = 2'd1;
         end else if (m_n < LAT_OUT) begin
            e_rdy = 2'd3;
            e_bc  = 6'((m_n - LAT_RUN) % 64);
         end else begin
            e_rdy   = 2'd1;
            e_valid = 1'b1;
            e_ct    = exp_ct[m_n - LAT_OUT];
         end
         e_busy = (m_n >= 1 && m_n < LAT_DONE);
         e_done = (m_n == LAT_DONE);
`ifdef SIMON_ROUND_STROBE_EN
         e_str = (m_n > LAT_RUN && m_n <= LAT_OUT && ((m_n - LAT_RUN) % 64) == 0);
         a_str = bus.round_strobe;
`endif
         check($sformatf("cycle n=%0d rdy/bc/busy/done/valid/ct/strobe", m_n),
               128'({bus.data_rdy, bus.bit_counter, bus.busy, bus.done, bus.ct_valid,
                     bus.ct_valid & bus.ct_out, a_str}),
               128'({e_rdy, e_bc, e_busy, e_done, e_valid, e_valid & e_ct, e_str}));
      end
   end

   // ---------------- run-level observation of one encryption ----------------
   // Called on the negedge of cycle 1 (first cycle after the start edge);
   // returns on the negedge of the done cycle or when the budget runs out.
   task automatic collect(input string tag, input logic [127:0] exp_v, input int poke_c);
      logic [127:0] cap;
      logic [5:0]   pbc;
      logic [1:0]   prdy;
      int idx, c, wraps, strobes, last_str, gap_err;
      cap = '0; idx = 0; c = 1; wraps = 0; strobes = 0; last_str = 0; gap_err = 0;
      pbc = bus.bit_counter; prdy = bus.data_rdy;
      while (!bus.done && c < LAT_DONE + 64) begin
         @(negedge clk);
         c++;
         if (poke_c > 0) bus.start = (c == poke_c);
         if (bus.ct_valid && idx < 128) begin
            cap[idx] = bus.ct_out;
            idx++;
         end
         if (prdy == 2'd3 && bus.data_rdy == 2'd3 && pbc == 6'd63 && bus.bit_counter == 6'd0)
            wraps++;
         prdy = bus.data_rdy;
         pbc  = bus.bit_counter;
`ifdef SIMON_ROUND_STROBE_EN
         if (bus.round_strobe) begin
            if (strobes > 0 && (c - last_str) != 64) gap_err++;
            strobes++;
            last_str = c;
         end
`endif
      end
      check({tag, " done cycle"}, 128'(c), 128'(4737));
      check({tag, " ct bits seen"}, 128'(idx), 128'(128));
      check({tag, " ciphertext"}, cap, exp_v);
      check({tag, " bit_counter wraps"}, 128'(wraps), 128'(67));
`ifdef SIMON_ROUND_STROBE_EN
      check({tag, " strobe count"}, 128'(strobes), 128'(ROUNDS));
      check({tag, " strobe gaps"}, 128'(gap_err), 128'(0));
      check({tag, " last strobe cycle"}, 128'(last_str), 128'(4609));
`endif
   endtask

   task automatic encrypt(input string tag, input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] exp_v, input int poke_c);
      next_key = key;
      next_pt  = pt;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      collect(tag, exp_v, poke_c);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin : main
      logic [127:0] rk, rp;
      bus.start = 1'b0;
      next_key  = KAT_KEY;
      next_pt   = KAT_PT;
      cur_key   = KAT_KEY;
      cur_pt    = KAT_PT;
      exp_ct    = '0;

      #2 rst = 1'b1;
      #10;
      check("reset data_rdy",    128'(bus.data_rdy), 128'(0));
      check("reset bit_counter", 128'(bus.bit_counter), 128'(0));
      check("reset ct_out",      128'(bus.ct_out), 128'(0));
      check("reset ct_valid",    128'(bus.ct_valid), 128'(0));
      check("reset busy",        128'(bus.busy), 128'(0));
      check("reset done",        128'(bus.done), 128'(0));
`ifdef SIMON_ROUND_STROBE_EN
      check("reset round_strobe", 128'(bus.round_strobe), 128'(0));
`endif
      check("model known answer", simon_encrypt(KAT_KEY, KAT_PT), KAT_CT);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);

      // known answer
      encrypt("kat", KAT_KEY, KAT_PT, KAT_CT, 0);

      // start pulse while running is ignored
      encrypt("busy start", KAT_KEY, KAT_PT, KAT_CT, LAT_RUN + 1000);

      // reset in the middle of RUN
      next_key = KAT_KEY;
      next_pt  = KAT_PT;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (LAT_RUN + 2000 - 1) @(negedge clk);
      check("pre-abort data_rdy", 128'(bus.data_rdy), 128'(3));
      #1 rst = 1'b1;
      #1;
      check("abort data_rdy",    128'(bus.data_rdy), 128'(0));
      check("abort bit_counter", 128'(bus.bit_counter), 128'(0));
      check("abort busy",        128'(bus.busy), 128'(0));
      check("abort ct_valid",    128'(bus.ct_valid), 128'(0));
      check("abort ct_out",      128'(bus.ct_out), 128'(0));
      check("abort done",        128'(bus.done), 128'(0));
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      encrypt("after abort", KAT_KEY, KAT_PT, KAT_CT, 0);

      // back-to-back with start held high: second run begins in the done cycle
      rk = rand128();
      rp = rand128();
      next_key = KAT_KEY;
      next_pt  = KAT_PT;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk);
      next_key = rk;
      next_pt  = rp;
      collect("b2b first", KAT_CT, 0);
      check("b2b done-cycle busy", 128'(bus.busy), 128'(0));
      @(negedge clk); bus.start = 1'b0;
      check("b2b second started", 128'(bus.data_rdy), 128'(2));
      collect("b2b second", simon_encrypt(rk, rp), 0);

      // randomized vectors with a stray start somewhere in the run
      for (int t = 0; t < 2; t++) begin
         rk = rand128();
         rp = rand128();
         encrypt($sformatf("random %0d", t), rk, rp, simon_encrypt(rk, rp),
                 int'($urandom_range(3, LAT_DONE - 2)));
      end

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
